// File: rtl/fdenorm_shift_pkg.sv
// ---------------------------------------------------------------------------
// fdenorm_shift_pkg
// Shared constants and types for the denormalizing right-shift stage.
//   DEN_EXT / DEN_DBL : exponent encodings written for denormal results
//   *_BIT / *_HI / *_LO : bit positions inside the 82-bit internal operand
//   fdn_stage_t        : payload carried from the coarse to the fine stage
// ---------------------------------------------------------------------------
package fdenorm_shift_pkg;

  localparam logic [15:0] DEN_EXT = 16'h4000;
  localparam logic [11:0] DEN_DBL = 12'h400;

  localparam int SIGN_BIT    = 81;
  localparam int EXT_EXP_HI  = 80;
  localparam int EXT_EXP_LO  = 66;
  localparam int EXP_TOP_BIT = 65;
  localparam int TAG_BIT     = 64;
  localparam int DBL_EXP_HI  = 63;
  localparam int DBL_EXP_LO  = 53;

  localparam int EXT_MANT_W  = 64;
  localparam int DBL_MANT_W  = 53;
  localparam int WORD_W      = 130;

  // Coarse-shifted mantissa word plus everything the fine stage needs.
  typedef struct packed {
    logic              sign;
    logic              tag;
    logic              is_dbl;
    logic [2:0]        fine_sh;
    logic              denorm;
    logic              valid;
    logic [WORD_W-1:0] word;
  } fdn_stage_t;

endpackage

// File: rtl/fdenorm_shift_sticky_or.sv
// ---------------------------------------------------------------------------
// fdn_sticky_or
// Parameterized-width OR reduction used for sticky and mantissa-nonzero flags.
//   vec     : bits to reduce (W wide)
//   any_set : 1 when any bit of vec is set
// ---------------------------------------------------------------------------
module fdn_sticky_or #(
  parameter int W = 8
) (
  input  logic [W-1:0] vec,
  output logic         any_set
);

  assign any_set = |vec;

endmodule

// File: rtl/fdenorm_shift.sv
// ---------------------------------------------------------------------------
// fdenorm_shift
// Two-stage denormalizing right shifter. Operands whose exponent is below the
// minimum normal exponent get their mantissa shifted right by the offset,
// the exponent pinned to the denormal encoding, and guard/round/sticky bits
// produced for the rounding stage. Stage 1 shifts by multiples of 8, stage 2
// by the remaining 0..7 and forms the outputs. Both stages hold on clkEn=0.
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   clkEn         pipeline advance
//   en            input valid
//   A             82-bit operand (sign 81, EXT exp {65,80:66}, tag 64,
//                 EXT mantissa 63:0 / DBL exp {65,63:53}, mantissa 52:0)
//   isDBL, isEXT  format select (isDBL wins; otherwise extended)
//   offset        two's-complement denormal offset
//   res, grs      shifted operand and guard/round/sticky
//   res_vld       output valid
//   inexact       OR of grs, qualified by res_vld
//
// Build option: define FDENORM_FTZ_EN to flush every denormal result to a
// signed zero instead of producing a gradual-underflow mantissa.
// ---------------------------------------------------------------------------
module fdenorm_shift #(
  parameter int MSH = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic        en,
  input  logic [81:0] A,
  input  logic        isDBL,
  input  logic        isEXT,
  input  logic [15:0] offset,
  output logic [81:0] res,
  output logic [2:0]  grs,
  output logic        res_vld,
  output logic        inexact
);

  import fdenorm_shift_pkg::*;

  // Only two formats exist; anything not double is treated as extended.
  logic unused_isext;
  assign unused_isext = isEXT;

  logic [63:0]       mant_in;
  logic [MSH-1:0]    sh;
  logic              sat;
  logic              m_nz;
  logic [WORD_W-1:0] coarse_word;

  assign mant_in = isDBL ? {A[52:0], 11'b0} : A[63:0];

  // Negative or zero offsets mean a normal number; anything past the shifter
  // range saturates to the all-ones shift amount.
  always_comb begin
    sh = '0;
    if (offset[15]) begin
      sh = '0;
    end else if (|offset[14:MSH]) begin
      sh = '1;
    end else begin
      sh = offset[MSH-1:0];
    end
  end

  // Beyond width+2 the whole mantissa lands in sticky, but some bits fall
  // off the bottom of the 130-bit word, so sticky comes from the raw mantissa.
  assign sat = isDBL ? (32'(sh) >= DBL_MANT_W + 2) : (32'(sh) >= EXT_MANT_W + 2);

  assign coarse_word = {mant_in, 66'b0} >> {sh[MSH-1:3], 3'b000};

  fdn_sticky_or #(.W(64)) u_mant_or (
    .vec     (mant_in),
    .any_set (m_nz)
  );

  fdn_stage_t  s1;
  logic [15:0] hi_s1;
  logic [10:0] dexp_s1;
  logic        sat_s1;
  logic        m_nz_s1;

  // Stage 1: capture the coarse-shifted word and the pass-through fields.
  // Data loads even for bubbles; only the valid bit tracks en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1      <= '0;
      hi_s1   <= '0;
      dexp_s1 <= '0;
      sat_s1  <= 1'b0;
      m_nz_s1 <= 1'b0;
    end else if (clkEn) begin
      s1.sign    <= A[SIGN_BIT];
      s1.tag     <= A[TAG_BIT];
      s1.is_dbl  <= isDBL;
      s1.fine_sh <= sh[2:0];
      s1.denorm  <= (sh != '0);
      s1.valid   <= en;
      s1.word    <= coarse_word;
      hi_s1      <= A[EXT_EXP_HI:EXP_TOP_BIT];
      dexp_s1    <= A[DBL_EXP_HI:DBL_EXP_LO];
      sat_s1     <= sat;
      m_nz_s1    <= m_nz;
    end
  end

  logic [WORD_W-1:0] fine_word;
  logic              ext_sticky;
  logic              dbl_sticky;
  logic [81:0]       res_next;
  logic [2:0]        grs_next;
  logic              inexact_next;

  assign fine_word = s1.word >> s1.fine_sh;

  fdn_sticky_or #(.W(64)) u_ext_or (
    .vec     (fine_word[63:0]),
    .any_set (ext_sticky)
  );

  fdn_sticky_or #(.W(75)) u_dbl_or (
    .vec     (fine_word[74:0]),
    .any_set (dbl_sticky)
  );

  // Stage 2: fine shift, rebuild the operand and pick guard/round/sticky
  // from the format-specific positions in the shifted word.
  always_comb begin
    res_next                          = '0;
    res_next[SIGN_BIT]                = s1.sign;
    res_next[EXT_EXP_HI:EXP_TOP_BIT]  = hi_s1;
    res_next[TAG_BIT]                 = s1.tag;
    res_next[DBL_EXP_HI:DBL_EXP_LO]   = dexp_s1;
    grs_next                          = '0;
    if (s1.is_dbl) begin
      res_next[52:0] = fine_word[129:77];
      grs_next = {fine_word[76], fine_word[75], sat_s1 ? m_nz_s1 : dbl_sticky};
      if (s1.denorm) begin
        {res_next[EXP_TOP_BIT], res_next[DBL_EXP_HI:DBL_EXP_LO]} = DEN_DBL;
      end
    end else begin
      res_next[63:0] = fine_word[129:66];
      grs_next = {fine_word[65], fine_word[64], sat_s1 ? m_nz_s1 : ext_sticky};
      if (s1.denorm) begin
        {res_next[EXP_TOP_BIT], res_next[EXT_EXP_HI:EXT_EXP_LO]} = DEN_EXT;
      end
    end
    inexact_next = |grs_next;
`ifdef FDENORM_FTZ_EN
    if (s1.denorm) begin
      if (s1.is_dbl) begin
        res_next[52:0] = '0;
      end else begin
        res_next[63:0] = '0;
      end
      grs_next     = 3'b001;
      inexact_next = m_nz_s1;
    end
`endif
  end

  // Output registers; reset wins over a stalled pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res     <= '0;
      grs     <= '0;
      res_vld <= 1'b0;
      inexact <= 1'b0;
    end else if (clkEn) begin
      res     <= res_next;
      grs     <= grs_next;
      res_vld <= s1.valid;
      inexact <= s1.valid & inexact_next;
    end
  end

endmodule

// File: tb/tb_fdenorm_shift.sv
// ---------------------------------------------------------------------------
// tb_fdenorm_shift
// Scoreboard bench for fdenorm_shift: stimulus pushes model results into a
// queue, a monitor pops and compares on every enabled edge with res_vld=1.
// ---------------------------------------------------------------------------
module tb_fdenorm_shift;

  typedef struct {
    logic [81:0] res;
    logic [2:0]  grs;
    logic        inexact;
  } want_t;

  logic        clk;
  logic        rst;
  logic        clkEn;
  logic        en;
  logic [81:0] A;
  logic        isDBL;
  logic        isEXT;
  logic [15:0] offset;
  logic [81:0] res;
  logic [2:0]  grs;
  logic        res_vld;
  logic        inexact;

  want_t want_q[$];
  want_t last_want;
  int    n_checks;
  int    n_pass;

  fdenorm_shift dut (
    .clk     (clk),
    .rst     (rst),
    .clkEn   (clkEn),
    .en      (en),
    .A       (A),
    .isDBL   (isDBL),
    .isEXT   (isEXT),
    .offset  (offset),
    .res     (res),
    .grs     (grs),
    .res_vld (res_vld),
    .inexact (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: mantissa shifted right by the clamped offset; every bit that
  // falls out is classified as guard, round or sticky by its distance.
  function automatic want_t model(input logic [81:0] a, input logic dbl, input logic [15:0] off);
    want_t w;
    int sh;
    int width;
    logic [63:0] m;
    logic [63:0] kept;
    logic g, r, s;
    if (off[15] || off == 16'd0) sh = 0;
    else if (off > 16'd127) sh = 127;
    else sh = int'(off);
    width = dbl ? 53 : 64;
    m = dbl ? {11'b0, a[52:0]} : a[63:0];
    g = 1'b0; r = 1'b0; s = 1'b0;
    for (int i = 0; i < width; i++) begin
      if (m[i]) begin
        if (i == sh - 1) g = 1'b1;
        else if (i == sh - 2) r = 1'b1;
        else if (i < sh - 2) s = 1'b1;
      end
    end
    kept = (sh >= 64) ? 64'd0 : (m >> sh);
    w.res = a;
    w.grs = {g, r, s};
    w.inexact = g | r | s;
`ifdef FDENORM_FTZ_EN
    if (sh != 0) begin
      kept = 64'd0;
      w.grs = 3'b001;
      w.inexact = (m != 64'd0);
    end
`endif
    if (dbl) begin
      w.res[52:0] = kept[52:0];
      if (sh != 0) {w.res[65], w.res[63:53]} = 12'h400;
    end else begin
      w.res[63:0] = kept;
      if (sh != 0) {w.res[65], w.res[80:66]} = 16'h4000;
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [81:0] act, input logic [81:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic applyStimulus(input logic [81:0] a, input logic dbl, input logic [15:0] off,
                               input logic v, input logic ce);
    @(negedge clk);
    A = a; isDBL = dbl; isEXT = ~dbl; offset = off; en = v; clkEn = ce;
    @(posedge clk);
    if (v && ce && rst) want_q.push_back(model(a, dbl, off));
  endtask

  function automatic logic [81:0] rand_a();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [15:0] rand_offset(input logic dbl);
    case ($urandom_range(0, 5))
      0: return 16'd0;
      1: return 16'($urandom_range(1, 8));
      2: return 16'($urandom_range(1, dbl ? 60 : 70));
      3: return 16'h8000 | 16'($urandom);
      4: return 16'($urandom_range(128, 32767));
      default: return 16'($urandom_range(100, 127));
    endcase
  endfunction

  function automatic logic [81:0] ext_op(input logic [63:0] m);
    logic [81:0] a;
    a = '0;
    a[81] = 1'b1;
    a[64] = 1'b1;
    {a[65], a[80:66]} = 16'h3FF0;
    a[63:0] = m;
    return a;
  endfunction

  // Monitor: compare on each enabled, non-reset edge presenting a valid.
  always @(posedge clk) begin
    logic ce_s, rst_s;
    want_t w;
    ce_s = clkEn;
    rst_s = rst;
    #1;
    if (ce_s && rst_s && res_vld) begin
      if (want_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_valid: res_vld=1, expected no output");
      end else begin
        w = want_q.pop_front();
        last_want = w;
        checkOutput("res", res, w.res);
        checkOutput("grs", 82'(grs), 82'(w.grs));
        checkOutput("inexact", 82'(inexact), 82'(w.inexact));
      end
    end
  end

  initial begin
    logic [81:0] a;
    logic        dbl;
    n_checks = 0;
    n_pass = 0;
    rst = 1'b0; clkEn = 1'b0; en = 1'b1; A = '1; isDBL = 1'b0; isEXT = 1'b1; offset = 16'd5;

    // Reset must clear the outputs even with clkEn low.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_res", res, 82'd0);
    checkOutput("reset_grs", 82'(grs), 82'd0);
    checkOutput("reset_vld", 82'(res_vld), 82'd0);
    checkOutput("reset_inexact", 82'(inexact), 82'd0);
    @(negedge clk);
    rst = 1'b1;

    // Unshifted EXT operand with a latency probe.
    applyStimulus(ext_op(64'h8000_0000_0000_0001), 1'b0, 16'd0, 1'b1, 1'b1);
    #2 checkOutput("latency_early", 82'(res_vld), 82'd0);
    applyStimulus('0, 1'b0, 16'd0, 1'b0, 1'b1);
    #2 checkOutput("latency_due", 82'(res_vld), 82'd1);

    applyStimulus(ext_op(64'h8000_0000_0000_000F), 1'b0, 16'd3, 1'b1, 1'b1);
    a = '0; a[81] = 1'b0; a[52:0] = 53'h1F_FFFF_FFFF_FFFF; {a[65], a[63:53]} = 12'h3C0;
    applyStimulus(a, 1'b1, 16'd1, 1'b1, 1'b1);
    applyStimulus(ext_op(64'd1), 1'b0, 16'h0200, 1'b1, 1'b1);
    applyStimulus(ext_op(64'h8000_0000_0000_0000), 1'b0, 16'd1, 1'b1, 1'b1);
    applyStimulus(ext_op(64'hFFFF_FFFF_FFFF_FFFF), 1'b0, 16'd66, 1'b1, 1'b1);
    applyStimulus(a, 1'b1, 16'd55, 1'b1, 1'b1);
    applyStimulus(a, 1'b1, 16'hFFFF, 1'b1, 1'b1);

    // Back-to-back valids then a 3-cycle stall: the output must hold.
    applyStimulus(ext_op(64'h1234_5678_9ABC_DEF0), 1'b0, 16'd13, 1'b1, 1'b1);
    applyStimulus(ext_op(64'h0FED_CBA9_8765_4321), 1'b0, 16'd7, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(rand_a(), 1'b0, 16'd9, 1'b1, 1'b0);
      #2;
      checkOutput("stall_res", res, last_want.res);
      checkOutput("stall_vld", 82'(res_vld), 82'd1);
    end
    applyStimulus('0, 1'b0, 16'd0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 16'd0, 1'b0, 1'b1);

    // Reset mid-stream discards both stages.
    applyStimulus(rand_a(), 1'b0, 16'd4, 1'b1, 1'b1);
    applyStimulus(rand_a(), 1'b1, 16'd2, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    @(posedge clk);
    #2 checkOutput("midreset_vld", 82'(res_vld), 82'd0);
    want_q.delete();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic with random stalls and bubbles.
    for (int i = 0; i < 400; i++) begin
      dbl = 1'($urandom_range(0, 1));
      applyStimulus(rand_a(), dbl, rand_offset(dbl),
                    $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0);
    end

    // Drain with a bounded number of cycles.
    for (int i = 0; i < 10 && want_q.size() != 0; i++) begin
      applyStimulus('0, 1'b0, 16'd0, 1'b0, 1'b1);
    end
    #2;
    checkOutput("drain_empty", 82'(want_q.size()), 82'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fdenorm_shift.md
# fdenorm_shift

Denormalizing right-shift stage that sits directly downstream of the FP denormal-offset stage in the math pipeline. It takes an 82-bit internal-format operand and the 16-bit offset `offset = denor_from - exp`. When the exponent lies below the minimum normal exponent, it shifts the mantissa right by that amount and pins the exponent to the denormal encoding. It also produces guard/round/sticky bits for the following rounding stage. The block is a two-stage pipeline that stalls on `clkEn`.

## Interface
Parameters:
- `MSH`, 7: shift-amount width; shifts saturate at 2^MSH-1 = 127.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge (0 = reset).
- `clkEn`  in  1  pipeline advance; when 0, every register holds.
- `en`  in  1  input valid.
- `A`  in  82  operand: A[81] sign, {A[65],A[80:66]} EXT exponent, A[63:0] EXT mantissa (explicit integer bit), A[64] tag (passed through).
- `isDBL`  in  1  double: exponent {A[65],A[63:53]}, mantissa A[52:0].
- `isEXT`  in  1  extended format; ignored when `isDBL`=1.
- `offset`  in  16  two's-complement denormal offset from the upstream stage.
- `res`  out  82  shifted operand, same layout as `A`.
- `grs`  out  3  guard, round, sticky.
- `res_vld`  out  1  output valid.
- `inexact`  out  1  OR of `grs`, qualified by `res_vld`.

## Operation
- Left-aligned mantissa: M = isDBL ? {A[52:0],11'b0} : A[63:0].
- Shift amount:
  - sh = 0 if offset[15]=1 or offset=0.
  - sh = 127 if offset[14:7]≠0.
  - Otherwise sh = offset[6:0].
- Stage 1 (coarse): shift {M,66'b0} right by 8·sh[6:3]; latch sign, tag, format, sh[2:0], the "denormal" flag (sh≠0), and valid.
- Stage 2 (fine): shift right by sh[2:0].
  - EXT: mantissa = bits [129:66]; G = bit 65, R = bit 64, S = OR[63:0].
  - DBL: mantissa = bits [129:77] → A[52:0]; G = 76, R = 75, S = OR[74:0].
- Denormal exponent value: EXT {A65,A80:66} = 16'h4000; DBL {A65,A63:53} = 12'h400. It is written when the denormal flag is set; otherwise the exponent passes through unchanged.
- Saturated shift (sh ≥ width+2): mantissa = 0, G = R = 0, S = OR of M.
- Sign, tag, and A[64] always pass through.
- `en`=0 inputs propagate as bubbles, with `res_vld`=0. Data registers still load, so no value is guaranteed while `res_vld`=0.

## Timing
- Latency: 2 enabled cycles. An input accepted at edge n with clkEn=1 appears at edge n+1 with clkEn=1 (its second enabled edge).
- Throughput: 1 per enabled cycle; no backpressure output.
- Reset (rst=0 at an edge): both valids clear, `res`=0, `grs`=0, `inexact`=0. Reset overrides `clkEn`=0.
- A reset mid-flight discards both stages. The first valid output after reset release needs 2 enabled edges.
- `clkEn`=0 while `en`=1: the input is not captured; upstream must hold it.

## Configuration
- `FDENORM_FTZ_EN`:
  - Defined: any operand with sh≠0 produces a signed zero (mantissa 0, exponent = denormal encoding, sign kept), `grs`=3'b001, and `inexact`=1 when M≠0.
  - Undefined: gradual underflow as described above.

## Structure
- Shared math package holds:
  - the DEN_DBL/DEN_EXT constants;
  - the 82-bit field bit-position localparams;
  - an `fdn_stage_t` struct (sign, tag, isDBL, fine shift, denormal flag, valid, 130-bit word).
- One sub-module `fdn_sticky_or`: a parameterized-width OR reduction, used for the sticky bit and for the saturation sticky.

## Test plan
- EXT, exp = 16'h4000 (offset = 0), M = 64'h8000_0000_0000_0001 → res unchanged, grs = 000, res_vld two enabled cycles later.
- EXT, offset = 3, M = 64'h8000_0000_0000_000F → mantissa 64'h1000_0000_0000_0001, grs = 111, exponent = 16'h4000.
- DBL, offset = 1, A[52:0] = 53'h1F_FFFF_FFFF_FFFF → A[52:0] = 53'h0F_FFFF_FFFF_FFFF, grs = 100, DBL exponent = 12'h400.
- EXT, offset = 16'h0200 (saturate), M = 1 → mantissa 0, grs = 001, inexact = 1.
- Back-to-back valids with clkEn = 0 for 3 cycles between them → outputs held, no duplicate res_vld; rst = 0 mid-stream → res_vld = 0 on the next edge.
- FDENORM_FTZ_EN build, EXT offset = 1, M = 64'h8000_0000_0000_0000 → mantissa 0, sign kept, grs = 001.
